// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO mode constants and address-width helper
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// rtl/fifo_ptr_wrap.sv - address counter wrapping at DEPTH-1 for any DEPTH
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = fifo_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  // Explicit compare so non-power-of-two depths wrap correctly.
  always_comb begin
    addr_d = addr_q;
    if (inc) begin
      addr_d = (addr_q == LAST) ? '0 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with any depth, STD/FWFT read and sticky errors
module sync_fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 8,
  parameter  int AFULL_TH  = DEPTH - 2,
  parameter  int AEMPTY_TH = 2,
  parameter  int FWFT      = FIFO_STD,
  localparam int AW        = fifo_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be at least 2");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_th
    $error("sync_fifo: thresholds must satisfy 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
    $error("sync_fifo: FWFT must be 0 or 1");
  end

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW + 1)'(AFULL_TH);
  localparam logic [AW:0] AEMPT_C = (AW + 1)'(AEMPTY_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc;
  logic             rd_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPT_C);
  assign wr_acc       = wr_en & ~full;
  assign rd_acc       = rd_en & ~empty;

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (wr_acc),
    .addr (wr_addr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (rd_acc),
    .addr (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A set condition wins over clr_err in the same cycle.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d  = (wr_en & full)  | (overflow_q  & ~clr_err);
    underflow_d = (rd_en & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rd_data  = mem_q[rd_addr];
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
      rd_data_d  = rd_acc ? mem_q[rd_addr] : rd_data_q;
      rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - checks STD and FWFT sync_fifo instances against a queue model
module tb_sync_fifo;

  localparam int D = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] s_count, f_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_udf, m_valid;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(8), .DEPTH(D), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(D), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("s_count", 32'(s_count), 32'(n));
    check("s_full",  32'(s_full),  32'(n == D));
    check("s_empty", 32'(s_empty), 32'(n == 0));
    check("s_afull", 32'(s_af),    32'(n >= 4));
    check("s_aempty", 32'(s_ae),   32'(n <= 1));
    check("s_ovf",   32'(s_ovf),   32'(m_ovf));
    check("s_udf",   32'(s_udf),   32'(m_udf));
    check("s_rd_valid", 32'(s_rd_valid), 32'(m_valid));
    check("s_rd_data",  32'(s_rd_data),  32'(m_data));
    check("f_count", 32'(f_count), 32'(n));
    check("f_full",  32'(f_full),  32'(n == D));
    check("f_empty", 32'(f_empty), 32'(n == 0));
    check("f_ovf",   32'(f_ovf),   32'(m_ovf));
    check("f_udf",   32'(f_udf),   32'(m_udf));
    check("f_rd_valid", 32'(f_rd_valid), 32'(n > 0));
    if (n > 0) check("f_rd_data", 32'(f_rd_data), 32'(q[0]));
  endtask

  task automatic cycle(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    int n;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    clr_err = clr;
    @(posedge clk);
    n = q.size();
    m_ovf = (wr && n == D) || (m_ovf && !clr);
    m_udf = (rd && n == 0) || (m_udf && !clr);
    if (rd && n > 0) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wr && n < D) q.push_back(d);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end

    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    rst = 1'b0;
    #1;
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b1, 8'hB6, 1'b0, 1'b0);
    cycle(1'b1, 8'hC7, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      bit w, r, c;
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 15) == 0);
      cycle(w, 8'($urandom_range(0, 255)), r, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the next generation of the team's FIFO family. Supports any integer DEPTH (not only powers of two), standard or first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It sits inside a clock domain wherever buffering with flow-control status is needed, for example behind a CDC stage or between pipeline blocks.

## Interface
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of entries; any integer ≥ 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write word.
- rd_en  in  1  read request (pop acknowledge when FWFT=1).
- clr_err  in  1  synchronous clear of overflow and underflow.
- rd_data  out  WIDTH  read word.
- rd_valid  out  1  rd_data holds a valid word.
- full / empty  out  1 each  count == DEPTH / count == 0.
- almost_full / almost_empty  out  1 each  threshold flags.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow / underflow  out  1 each  sticky error flags.

## Operation
- Write is accepted when wr_acc = wr_en & !full. Read is accepted when rd_acc = rd_en & !empty. A write on full is dropped, even if a read is accepted in the same cycle.
- Write and read addresses increment on acceptance and wrap from DEPTH-1 to 0. Wrap uses an explicit compare, not a power-of-two modulo.
- count changes by +1 on write only, −1 on read only, and is unchanged when both or neither are accepted.
- full, empty, almost_full and almost_empty are decoded combinationally from the count register.
- FWFT=0: on rd_acc, rd_data is loaded with the head word and rd_valid pulses high for exactly one cycle. Otherwise rd_data holds its last value and rd_valid is 0.
- FWFT=1: rd_data = mem[rd_addr] combinationally and rd_valid = !empty. rd_acc pops the head; the next word is visible after that edge.
- overflow sets on wr_en & full. underflow sets on rd_en & empty. Both stay set until clr_err. If a set condition and clr_err occur in the same cycle, the flag remains set.
- Elaboration error unless DEPTH ≥ 2, 0 ≤ AEMPTY_TH < AFULL_TH ≤ DEPTH, and FWFT ∈ {0, 1}.
- Reset values: addresses 0, count 0, rd_data 0, rd_valid 0, overflow 0, underflow 0. This gives empty=1, almost_empty=1, full=0, and almost_full=0. Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately and asynchronously. The first accepted write after release lands at address 0.

## Timing
- Write-to-read visibility: a word written at edge N can be read from edge N+1. In FWFT mode it appears on rd_data after edge N.
- FWFT=0 read latency: rd_data and rd_valid are valid one cycle after the rd_acc edge.
- Status flags and count update in the same edge as the accepted operation; no extra pipeline stage.
- Full throughput of one write and one read per cycle whenever 0 < count < DEPTH.
- At count == 0 with simultaneous wr_en and rd_en: write accepted, read rejected, underflow sets.
- At count == DEPTH with simultaneous wr_en and rd_en: read accepted, write dropped, overflow sets.

## Structure
- Shared package/header fifo_pkg holds the mode constants FIFO_STD=0 and FIFO_FWFT=1, plus the clog2 helper used for AW.
- One natural sub-module, fifo_ptr_wrap: parametrised by DEPTH, with inputs clk, rst, inc and output addr [AW-1:0]. It wraps at DEPTH-1 and is instantiated for both the write and read addresses.
- Memory is a plain register array in the top module. The count register and flag decode also live in the top module.

## Test plan
- Setup: DEPTH=5, WIDTH=8, FWFT=0, AFULL_TH=4, AEMPTY_TH=1.
  - Reset, then write 0x11..0x55 -> full=1 after the 5th write, count=5, almost_full=1 from count=4. A 6th write sets overflow and leaves count=5.
  - Read 5 words -> rd_data = 0x11, 0x22, 0x33, 0x44, 0x55, each with a one-cycle rd_valid pulse one cycle after its rd_en. Then empty=1.
  - Wrap-around: 13 writes and 13 reads interleaved, keeping count ≤ 3 -> data order preserved across address wrap 4→0, no flag errors.
  - Simultaneous write and read at count=2 for 10 cycles -> count stays 2, output stream matches input stream.
  - rd_en while empty -> underflow=1. clr_err and rd_en-on-empty in the same cycle -> underflow stays 1. clr_err alone -> underflow=0.
- Setup: FWFT=1.
  - Write 0xA5 into the empty FIFO -> rd_valid=1 and rd_data=0xA5 after that edge. Pulse rst mid-stream at count=3 -> count=0, empty=1, rd_valid=0 immediately.
